midi_voice_allocator: RTL
=========================

# midi_voice_allocator

Polyphonic voice scheduler between the MIDI decode path and the waveform generators. Accepts decoded note-on and note-off events over a valid/ready handshake. Assigns each note-on to one of `NUM_VOICES` voice slots, releases slots on note-off, and steals the least-recently-allocated slot when all slots are busy. Drives per-voice note, velocity, active, start and stop signals consumed by the wave generators.

## Interface
- `NUM_VOICES`, 4: number of voice slots; power of two, 2..16.
- `NOTE_W`, 7: MIDI note number width.
- `VEL_W`, 8: velocity width, matching the decode datapath `veloc` output.

- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `evValid`  in  1  event present.
- `evReady`  out  1  allocator can accept an event.
- `evNoteOn`  in  1  1 = note-on, 0 = note-off.
- `evNote`  in  NOTE_W  note number.
- `evVelocity`  in  VEL_W  velocity.
- `voiceActive`  out  NUM_VOICES  slot i is sounding.
- `voiceNote`  out  NUM_VOICES*NOTE_W  slot i note in bits [i*NOTE_W +: NOTE_W].
- `voiceVelocity`  out  NUM_VOICES*VEL_W  slot i velocity in bits [i*VEL_W +: VEL_W].
- `voiceStart`  out  NUM_VOICES  one-cycle pulse: slot i (re)triggered.
- `voiceStop`  out  NUM_VOICES  one-cycle pulse: slot i released or stolen.
- `stealCount`  out  8  count of steals; saturates at 255.

## Operation
- **FSM states: IDLE → SEARCH → COMMIT → IDLE.**
  - IDLE: `evReady` = 1. On `evValid & evReady`, latch `evNoteOn`, `evNote` and `evVelocity`, then go to SEARCH. Inputs are sampled only at this acceptance edge.
  - SEARCH: compute the match, free and oldest indices from registered state. Register the decision and go to COMMIT.
  - COMMIT: update the voice registers and the pulses, then go to IDLE.
- **Normalisation:** a note-on with velocity 0 is treated as a note-off.
- **Note-on decision, in priority order:**
  1. An active slot already holds `evNote`: retrigger the lowest-index such slot. Update its velocity, pulse `voiceStart`, refresh its rank.
  2. Otherwise, if any slot is inactive: use the lowest-index inactive slot. Set active, load note and velocity, pulse `voiceStart`, rank 0.
  3. Otherwise steal the slot with rank `NUM_VOICES-1`. Pulse `voiceStop` and `voiceStart` on that slot in the same cycle, load the new note and velocity, increment `stealCount` (saturating).
- **Note-off:** clear `voiceActive` on the lowest-index active slot whose note matches, and pulse its `voiceStop`. With no match the event is consumed and has no effect; no pulses. `voiceNote` and `voiceVelocity` keep their last values after release.
- **Age ranks:**
  - Each slot holds a rank of clog2(NUM_VOICES) bits. The ranks always form a permutation of 0..NUM_VOICES-1.
  - On allocate, retrigger or steal of slot v with rank r: every slot with rank < r increments, and v becomes 0.
  - Note-off does not change ranks.
- **Pulses:** `voiceStart` and `voiceStop` are registered and high for exactly one cycle. At most one slot pulses per event.

## Timing
- Event accepted at edge E. SEARCH during cycle E+1. COMMIT during E+2. At edge E+2 the outputs update.
- Pulses and new `voiceActive` / note / velocity values are visible during cycle E+3, and `evReady` is high again in E+3.
- Throughput: one event per 3 cycles. `evReady` is combinational: (state == IDLE) & ~Reset.
- An upstream producer may hold `evValid` high continuously. Exactly one event is consumed per handshake.
- **Reset (asynchronous, any time, including mid-SEARCH/COMMIT):**
  - State = IDLE; any in-flight event is discarded.
  - `voiceActive`, `voiceNote`, `voiceVelocity`, `voiceStart`, `voiceStop` and `stealCount` = 0.
  - Rank of slot i = i.
  - `evReady` = 0 while Reset is high, and 1 in the first cycle after deassertion.
- All outputs are registered except `evReady`.

## Test plan
- **Reset values:** Reset mid-COMMIT of note-on 60 → no `voiceStart` pulse ever appears. All outputs are 0 and `evReady` = 1 the cycle after Reset falls.
- **Fill and latency:** note-ons 60, 62, 64, 67 (velocity 100), `evValid` held high → slots 0..3 get `voiceStart` pulses 3 cycles apart, `voiceActive` = 4'b1111, `stealCount` = 0.
- **Steal:** after the fill, note-on 72 → slot 0 (oldest) pulses stop and start together, note = 72, `stealCount` = 1. A further note-on 74 steals slot 1.
- **Release and reuse:** note-off 64 → `voiceStop`[2], `voiceActive` = 4'b1011. Then note-on 50 reuses slot 2. Then note-off 99 (no match) → no pulses, state unchanged.
- **Retrigger and velocity-0:** active note 62 with note-on 62 velocity 30 → same slot restarts, velocity = 30, no steal. Note-on 62 velocity 0 → behaves as note-off.
- **Saturation:** 300 steals → `stealCount` holds at 255.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: assigns MIDI note events to voice slots, retriggering
// matching notes, filling free slots, or stealing the least-recently-allocated slot.
module midi_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 7,
  parameter int VEL_W      = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         evValid,
  output logic                         evReady,
  input  logic                         evNoteOn,
  input  logic [NOTE_W-1:0]            evNote,
  input  logic [VEL_W-1:0]             evVelocity,
  output logic [NUM_VOICES-1:0]        voiceActive,
  output logic [NUM_VOICES*NOTE_W-1:0] voiceNote,
  output logic [NUM_VOICES*VEL_W-1:0]  voiceVelocity,
  output logic [NUM_VOICES-1:0]        voiceStart,
  output logic [NUM_VOICES-1:0]        voiceStop,
  output logic [7:0]                   stealCount
);
  localparam int IDX_W = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} stateE;
  typedef enum logic [1:0] {ACT_NONE, ACT_START, ACT_STEAL, ACT_RELEASE} actionE;

  stateE stateReg, stateNext;
  logic  accept, searchEn, commitEn;

  logic              isOnReg;
  logic [NOTE_W-1:0] noteReg;
  logic [VEL_W-1:0]  velReg;

  logic [NUM_VOICES-1:0] activeReg, startReg, stopReg;
  logic [NOTE_W-1:0]     noteArr [NUM_VOICES];
  logic [VEL_W-1:0]      velArr  [NUM_VOICES];
  logic [IDX_W-1:0]      rankArr [NUM_VOICES];
  logic [7:0]            stealReg;

  logic             matchFound, freeFound;
  logic [IDX_W-1:0] matchIdx, freeIdx, oldestIdx;
  actionE           actionNext, actionReg;
  logic [IDX_W-1:0] tgtNext, tgtReg;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (accept) stateNext = SEARCH;
      SEARCH:  stateNext = COMMIT;
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    evReady  = (stateReg == IDLE) & ~Reset;
    accept   = evValid & evReady;
    searchEn = (stateReg == SEARCH);
    commitEn = (stateReg == COMMIT);
  end

  // Velocity-0 note-on is folded into a note-off at capture time.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      isOnReg <= 1'b0;
      noteReg <= '0;
      velReg  <= '0;
    end else if (accept) begin
      isOnReg <= evNoteOn & (evVelocity != '0);
      noteReg <= evNote;
      velReg  <= evVelocity;
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    matchFound = 1'b0;
    freeFound  = 1'b0;
    matchIdx   = '0;
    freeIdx    = '0;
    oldestIdx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (activeReg[i] && (noteArr[i] == noteReg)) begin
        matchFound = 1'b1;
        matchIdx   = IDX_W'(i);
      end
      if (!activeReg[i]) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
      if (rankArr[i] == IDX_W'(NUM_VOICES - 1)) oldestIdx = IDX_W'(i);
    end
  end

  always_comb begin
    actionNext = ACT_NONE;
    tgtNext    = '0;
    if (isOnReg) begin
      if (matchFound) begin
        actionNext = ACT_START;
        tgtNext    = matchIdx;
      end else if (freeFound) begin
        actionNext = ACT_START;
        tgtNext    = freeIdx;
      end else begin
        actionNext = ACT_STEAL;
        tgtNext    = oldestIdx;
      end
    end else if (matchFound) begin
      actionNext = ACT_RELEASE;
      tgtNext    = matchIdx;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      actionReg <= ACT_NONE;
      tgtReg    <= '0;
    end else if (searchEn) begin
      actionReg <= actionNext;
      tgtReg    <= tgtNext;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      activeReg <= '0;
      startReg  <= '0;
      stopReg   <= '0;
      stealReg  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        noteArr[i] <= '0;
        velArr[i]  <= '0;
        rankArr[i] <= IDX_W'(i);
      end
    end else begin
      startReg <= '0;
      stopReg  <= '0;
      if (commitEn) begin
        case (actionReg)
          ACT_START, ACT_STEAL: begin
            activeReg[tgtReg] <= 1'b1;
            noteArr[tgtReg]   <= noteReg;
            velArr[tgtReg]    <= velReg;
            startReg[tgtReg]  <= 1'b1;
            // Move the target to the front; younger slots age by one.
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == tgtReg)              rankArr[i] <= '0;
              else if (rankArr[i] < rankArr[tgtReg]) rankArr[i] <= rankArr[i] + 1'b1;
            end
            if (actionReg == ACT_STEAL) begin
              stopReg[tgtReg] <= 1'b1;
              if (stealReg != 8'hFF) stealReg <= stealReg + 8'd1;
            end
          end
          ACT_RELEASE: begin
            activeReg[tgtReg] <= 1'b0;
            stopReg[tgtReg]   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_pack
      assign voiceNote[gi*NOTE_W +: NOTE_W]    = noteArr[gi];
      assign voiceVelocity[gi*VEL_W +: VEL_W]  = velArr[gi];
    end
  endgenerate

  assign voiceActive = activeReg;
  assign voiceStart  = startReg;
  assign voiceStop   = stopReg;
  assign stealCount  = stealReg;
endmodule
